// File: rtl/rv32i_lsu.sv
// RV32I load/store unit: single-outstanding req/ack access to data memory.
// Optional misaligned-access trap enabled by RV32I_LSU_MISALIGN_TRAP_EN.
module rv32i_lsu #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [4:0]  req_rd,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic [4:0]  resp_rd,
    output logic        resp_misaligned,
    output logic        resp_illegal,
    output logic        resp_timeout
);

    typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

    localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);

    state_t      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic [2:0]  f3_q, f3_d;
    logic        we_q, we_d;
    logic [4:0]  rd_q, rd_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        mis_q, mis_d;
    logic        ill_q, ill_d;
    logic        to_q, to_d;

    logic        illegal;
    logic        misal;
    logic [7:0]  ld_b;
    logic [15:0] ld_h;
    logic [31:0] ld_data;
    logic [31:0] st_data;
    logic [3:0]  st_strb;

    assign illegal = req_we ? (req_funct3 > 3'b010)
                            : (req_funct3 == 3'b011 || req_funct3[2:1] == 2'b11);

`ifdef RV32I_LSU_MISALIGN_TRAP_EN
    // An illegal funct3 takes precedence so only one flag is ever raised.
    assign misal = !illegal &&
                   ((req_funct3[1:0] == 2'b01 && req_addr[0]) ||
                    (req_funct3[1:0] == 2'b10 && req_addr[1:0] != 2'b00));
`else
    assign misal = 1'b0;
`endif

    assign ld_b = 8'(mem_rdata >> {addr_q[1:0], 3'b000});
    assign ld_h = 16'(mem_rdata >> {addr_q[1], 4'b0000});

    always_comb begin
        ld_data = '0;
        unique case (f3_q)
            3'b000:  ld_data = {{24{ld_b[7]}}, ld_b};
            3'b001:  ld_data = {{16{ld_h[15]}}, ld_h};
            3'b010:  ld_data = mem_rdata;
            3'b100:  ld_data = {24'h0, ld_b};
            3'b101:  ld_data = {16'h0, ld_h};
            default: ld_data = '0;
        endcase
    end

    // Offsets are masked to natural alignment for halfword and word.
    always_comb begin
        st_data = wdata_q;
        st_strb = 4'b1111;
        unique case (f3_q[1:0])
            2'b00: begin
                st_data = {4{wdata_q[7:0]}};
                st_strb = 4'b0001 << addr_q[1:0];
            end
            2'b01: begin
                st_data = {2{wdata_q[15:0]}};
                st_strb = 4'b0011 << {addr_q[1], 1'b0};
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        f3_d    = f3_q;
        we_d    = we_q;
        rd_d    = rd_q;
        cnt_d   = cnt_q;
        mis_d   = mis_q;
        ill_d   = ill_q;
        to_d    = to_q;
        unique case (state_q)
            IDLE: begin
                if (req_valid) begin
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    f3_d    = req_funct3;
                    we_d    = req_we;
                    rd_d    = req_rd;
                    rdata_d = '0;
                    cnt_d   = '0;
                    ill_d   = illegal;
                    mis_d   = misal;
                    to_d    = 1'b0;
                    state_d = (illegal || misal) ? RESP : REQ;
                end
            end
            REQ: begin
                if (mem_ack) begin
                    rdata_d = we_q ? 32'h0 : ld_data;
                    state_d = RESP;
                end else if (cnt_q == TO_LAST) begin
                    to_d    = 1'b1;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            f3_q    <= '0;
            we_q    <= 1'b0;
            rd_q    <= '0;
            cnt_q   <= '0;
            mis_q   <= 1'b0;
            ill_q   <= 1'b0;
            to_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            f3_q    <= f3_d;
            we_q    <= we_d;
            rd_q    <= rd_d;
            cnt_q   <= cnt_d;
            mis_q   <= mis_d;
            ill_q   <= ill_d;
            to_q    <= to_d;
        end
    end

    assign req_ready       = (state_q == IDLE);
    assign mem_req         = (state_q == REQ);
    assign mem_we          = mem_req && we_q;
    assign mem_addr        = {addr_q[31:2], 2'b00};
    assign mem_wdata       = mem_we ? st_data : 32'h0;
    assign mem_wstrb       = mem_we ? st_strb : 4'b0000;
    assign resp_valid      = (state_q == RESP);
    assign resp_rdata      = resp_valid ? rdata_q : 32'h0;
    assign resp_rd         = rd_q;
    assign resp_misaligned = resp_valid && mis_q;
    assign resp_illegal    = resp_valid && ill_q;
    assign resp_timeout    = resp_valid && to_q;

endmodule
